// File: rtl/efpga_cfg_pkg.sv
// Shared state encoding and parameter defaults for the eFPGA config loader.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package efpga_cfg_pkg;

  localparam int PRESET_CYC_DEF = 16;
  localparam int LEN_W_DEF      = 24;
  localparam int WORD_W         = 32;
  localparam int IDX_W          = $clog2(WORD_W);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESET,
    ST_WAIT_WORD,
    ST_SHIFT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/efpga_cfg_shifter.sv
// Serializer: holds one bitstream word, emits it LSB first, captures chain tail bits.
// Latency: head bit valid the cycle after load; one bit per shift cycle.
// Backpressure: none; load and shift are strobes owned by the controlling FSM.
module efpga_cfg_shifter
  import efpga_cfg_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  input  logic              shift,
  input  logic              tail_bit,
  output logic              head_bit,
  output logic              last_bit,
  output logic [WORD_W-1:0] tail_word
);

  logic [WORD_W-1:0] sreg;
  logic [IDX_W-1:0]  bidx;

  // Word register and bit index; a new word restarts the index at bit 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sreg <= '0;
      bidx <= '0;
    end else if (load) begin
      sreg <= word;
      bidx <= '0;
    end else if (shift) begin
      sreg <= {1'b0, sreg[WORD_W-1:1]};
      bidx <= bidx + IDX_W'(1);
    end
  end

  // Tail capture: newest bit enters at bit 0, value holds whenever not shifting.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tail_word <= '0;
    end else if (shift) begin
      tail_word <= {tail_word[WORD_W-2:0], tail_bit};
    end
  end

  assign head_bit = sreg[0];
  assign last_bit = (bidx == IDX_W'(WORD_W - 1));

endmodule

// File: rtl/efpga_cfg_loader.sv
// Loads an eFPGA configuration chain: preset pulse, then streams words LSB first into ccff_head.
// Latency: PRESET_CYC + (1 per word) + chain_len + 1 cycles from start to done pulse.
// Backpressure: word_ready only in WAIT_WORD; a late word simply stretches that state.
module efpga_cfg_loader
  import efpga_cfg_pkg::*;
#(
  parameter int PRESET_CYC = PRESET_CYC_DEF,
  parameter int LEN_W      = LEN_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [LEN_W-1:0] chain_len_i,
  input  logic             word_valid_i,
  input  logic [31:0]      word_data_i,
  output logic             word_ready_o,
  output logic             ccff_head_o,
  output logic             prog_clk_en_o,
  output logic             preset_o,
  input  logic             ccff_tail_i,
  output logic [31:0]      tail_word_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int PW = (PRESET_CYC > 1) ? $clog2(PRESET_CYC) : 1;

  state_t           state;
  logic [LEN_W-1:0] bit_cnt;
  logic [PW-1:0]    pre_cnt;
  logic             word_ready_q;
  logic             prog_clk_en_q;
  logic             preset_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             word_fire;
  logic             last_in_word;
  logic             head_bit;
  logic             word_end;

  assign word_fire = word_ready_q & word_valid_i;
  // A word ends at its 32nd bit or earlier when the chain runs out.
  assign word_end  = last_in_word | (bit_cnt == LEN_W'(1));

  // Control FSM; every output flop is written with the value for the state being entered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      pre_cnt       <= '0;
      word_ready_q  <= 1'b0;
      prog_clk_en_q <= 1'b0;
      preset_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_i && busy_q) begin
        state         <= ST_IDLE;
        err_q         <= 1'b1;
        word_ready_q  <= 1'b0;
        prog_clk_en_q <= 1'b0;
        preset_q      <= 1'b0;
        busy_q        <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            // abort alongside start drops the start
            if (start_i && !abort_i) begin
              if (chain_len_i == '0) begin
                err_q <= 1'b1;
              end else begin
                state    <= ST_PRESET;
                bit_cnt  <= chain_len_i;
                pre_cnt  <= PW'(PRESET_CYC - 1);
                err_q    <= 1'b0;
                preset_q <= 1'b1;
                busy_q   <= 1'b1;
              end
            end
          end
          ST_PRESET: begin
            if (pre_cnt == '0) begin
              state        <= ST_WAIT_WORD;
              preset_q     <= 1'b0;
              word_ready_q <= 1'b1;
            end else begin
              pre_cnt <= pre_cnt - PW'(1);
            end
          end
          ST_WAIT_WORD: begin
            if (word_fire) begin
              state         <= ST_SHIFT;
              word_ready_q  <= 1'b0;
              prog_clk_en_q <= 1'b1;
            end
          end
          ST_SHIFT: begin
            bit_cnt <= bit_cnt - LEN_W'(1);
            if (word_end) begin
              prog_clk_en_q <= 1'b0;
              if (bit_cnt == LEN_W'(1)) begin
                state  <= ST_DONE;
                done_q <= 1'b1;
              end else begin
                state        <= ST_WAIT_WORD;
                word_ready_q <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state         <= ST_IDLE;
            word_ready_q  <= 1'b0;
            prog_clk_en_q <= 1'b0;
            preset_q      <= 1'b0;
            busy_q        <= 1'b0;
          end
        endcase
      end
    end
  end

  efpga_cfg_shifter u_shifter (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load      (word_fire),
    .word      (word_data_i),
    .shift     (prog_clk_en_q),
    .tail_bit  (ccff_tail_i),
    .head_bit  (head_bit),
    .last_bit  (last_in_word),
    .tail_word (tail_word_o)
  );

  assign word_ready_o  = word_ready_q;
  assign prog_clk_en_o = prog_clk_en_q;
  // head is forced low outside shift cycles so stale word bits never reach the fabric
  assign ccff_head_o   = prog_clk_en_q & head_bit;
  assign preset_o      = preset_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_efpga_cfg_loader.sv
// Self-checking bench for efpga_cfg_loader: vector table plus corner-case sequences.
// Latency: expected head bits are queued at stimulus time and popped on each prog_clk_en cycle.
// Backpressure: a word feeder keeps word_valid high whenever the word queue is non-empty.
module tb_efpga_cfg_loader;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [23:0] chain_len_i = '0;
  logic        word_valid_i = 1'b0;
  logic [31:0] word_data_i = '0;
  logic        word_ready_o;
  logic        ccff_head_o;
  logic        prog_clk_en_o;
  logic        preset_o;
  logic        ccff_tail_i;
  logic [31:0] tail_word_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  efpga_cfg_loader dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .chain_len_i   (chain_len_i),
    .word_valid_i  (word_valid_i),
    .word_data_i   (word_data_i),
    .word_ready_o  (word_ready_o),
    .ccff_head_o   (ccff_head_o),
    .prog_clk_en_o (prog_clk_en_o),
    .preset_o      (preset_o),
    .ccff_tail_i   (ccff_tail_i),
    .tail_word_o   (tail_word_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  initial forever #5 clk_i = ~clk_i;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          done_cyc = 0;
  int          done_cnt = 0;
  int          en_cnt = 0;
  int          pre_cyc = 0;
  int          rdy_cyc = 0;
  logic [63:0] head_hist = '0;
  logic [31:0] wq[$];
  bit          exp_q[$];
  bit          hs_pending = 1'b0;
  bit          loop_en = 1'b0;
  logic [63:0] chain = '0;

  // 64-stage configuration chain model used for tail loopback
  assign ccff_tail_i = loop_en & chain[63];
  always @(posedge clk_i) if (prog_clk_en_o) chain <= {chain[62:0], ccff_head_o};

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Word feeder: retire a word after a handshake, present the next one.
  always @(posedge clk_i) begin
    #1;
    if (hs_pending && wq.size() > 0) void'(wq.pop_front());
    hs_pending   = 1'b0;
    word_valid_i = (wq.size() > 0);
    word_data_i  = (wq.size() > 0) ? wq[0] : 32'h0;
  end

  // Monitor on the falling edge, away from the active edge.
  always @(negedge clk_i) begin
    hs_pending = word_valid_i && word_ready_o && rst_ni;
    if (rst_ni) begin
      if (prog_clk_en_o) begin
        en_cnt++;
        head_hist = {head_hist[62:0], ccff_head_o};
        if (exp_q.size() == 0) check("head_extra_bit", 1, 0);
        else check("head_bit", ccff_head_o, exp_q.pop_front());
      end else begin
        check("head_idle_low", ccff_head_o, 0);
      end
      if (preset_o) pre_cyc++;
      if (word_ready_o) rdy_cyc++;
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Queue words for the feeder and the head bits they should produce.
  task automatic push_load(input int len, input int nw, input logic [31:0] w0,
                           input logic [31:0] w1, input logic [31:0] w2);
    logic [31:0] ws[3];
    int rem;
    int n;
    ws[0] = w0; ws[1] = w1; ws[2] = w2;
    rem = len;
    for (int i = 0; i < nw; i++) begin
      wq.push_back(ws[i]);
      n = (rem < 32) ? rem : 32;
      for (int b = 0; b < n; b++) exp_q.push_back(ws[i][b]);
      rem -= n;
    end
  endtask

  task automatic start_load(input int len);
    @(posedge clk_i); #1;
    en_cnt = 0; pre_cyc = 0; rdy_cyc = 0;
    start_i = 1'b1;
    chain_len_i = 24'(len);
    start_cyc = cyc;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < bound && done_cnt == d0; i++) begin
      @(posedge clk_i); #1;
    end
    check("done_seen", done_cnt - d0, 1);
  endtask

  task automatic wait_en(input int target, input int bound);
    for (int i = 0; i < bound && en_cnt < target; i++) begin
      @(posedge clk_i); #1;
    end
    check("shift_reached", en_cnt >= target, 1);
  endtask

  task automatic flush();
    wq.delete();
    exp_q.delete();
  endtask

  typedef struct {
    int          len;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    int          exp_delta;
    logic [7:0]  last8;
  } vec_t;

  vec_t        vt[5];
  logic [31:0] rev;

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    // expected done offsets: PRESET_CYC + words + len + 1
    vt[0] = '{32, 1, 32'hA5A5_0F0F, 32'h0,         32'h0, 50, 8'hA5};
    vt[1] = '{40, 2, 32'hFFFF_FFFF, 32'h0000_00AA, 32'h0, 59, 8'h55};
    vt[2] = '{8,  1, 32'hFFFF_FF0F, 32'h0,         32'h0, 26, 8'hF0};
    vt[3] = '{33, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0, 52, 8'hFE};
    vt[4] = '{64, 2, 32'h0000_0001, 32'h8000_0000, 32'h0, 83, 8'h01};

    // reset state
    #2 rst_ni = 1'b0;
    #1;
    check("reset_ctrl_outputs", {word_ready_o, ccff_head_o, prog_clk_en_o, preset_o,
                                 busy_o, done_o, err_o}, 0);
    check("reset_tail_word", tail_word_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // table-driven loads
    for (int v = 0; v < 5; v++) begin
      push_load(vt[v].len, vt[v].nw, vt[v].w0, vt[v].w1, vt[v].w2);
      start_load(vt[v].len);
      check("preset_active", {busy_o, preset_o}, 2'b11);
      wait_done(300);
      check("done_cycle", done_cyc - start_cyc, vt[v].exp_delta);
      check("en_cycles", en_cnt, vt[v].len);
      check("preset_cycles", pre_cyc, 16);
      check("ready_cycles", rdy_cyc, vt[v].nw);
      check("last8_head", head_hist[7:0], vt[v].last8);
      check("exp_drained", exp_q.size(), 0);
      check("idle_after_done", {busy_o, err_o}, 0);
    end

    // zero length: error, stays idle
    @(posedge clk_i); #1;
    start_i = 1'b1; chain_len_i = 24'd0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("len0_err", err_o, 1);
    check("len0_busy", busy_o, 0);
    @(posedge clk_i); #1;
    check("len0_busy_later", busy_o, 0);

    // start and abort together in idle: start dropped
    start_i = 1'b1; abort_i = 1'b1; chain_len_i = 24'd8;
    @(posedge clk_i); #1;
    start_i = 1'b0; abort_i = 1'b0;
    check("abort_wins_busy", {busy_o, preset_o}, 0);
    check("abort_wins_err_kept", err_o, 1);

    // start during SHIFT is ignored
    push_load(32, 1, 32'hA5A5_0F0F, 32'h0, 32'h0);
    start_load(32);
    check("start_clears_err", err_o, 0);
    wait_en(20, 100);
    start_i = 1'b1; chain_len_i = 24'd5;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wait_done(200);
    check("midshift_start_done", done_cyc - start_cyc, 50);
    check("midshift_start_en", en_cnt, 32);
    check("first8_head", head_hist[31:24], 8'hF0);

    // abort in the 10th SHIFT cycle
    push_load(64, 2, 32'h5555_5555, 32'h0, 32'h0);
    start_load(64);
    wait_en(9, 100);
    abort_i = 1'b1;
    @(posedge clk_i); #1;
    abort_i = 1'b0;
    check("abort_idle", {busy_o, prog_clk_en_o, word_ready_o, preset_o}, 0);
    check("abort_err", err_o, 1);
    repeat (3) @(posedge clk_i);
    #1;
    check("abort_en_count", en_cnt, 10);
    flush();
    push_load(8, 1, 32'hFFFF_FF0F, 32'h0, 32'h0);
    start_load(8);
    check("restart_clears_err", err_o, 0);
    wait_done(200);
    check("restart_en", en_cnt, 8);

    // tail loopback through a 64-bit chain; bit 0 holds the newest tail bit,
    // so the first word comes back bit-reversed in tail_word_o
    loop_en = 1'b1;
    push_load(96, 3, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F1E_2D3C);
    start_load(96);
    wait_done(400);
    for (int i = 0; i < 32; i++) rev[31-i] = 32'h1234_5678 >> i;
    check("loop_done_cycle", done_cyc - start_cyc, 116);
    check("loop_tail_word", tail_word_o, rev);
    loop_en = 1'b0;
    push_load(8, 1, 32'h0000_00C3, 32'h0, 32'h0);
    start_load(8);
    check("tail_held_on_start", tail_word_o, rev);
    wait_done(200);

    // asynchronous reset mid-SHIFT, then a fresh load
    push_load(64, 2, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0);
    start_load(64);
    wait_en(5, 100);
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst_ctrl", {word_ready_o, ccff_head_o, prog_clk_en_o, preset_o,
                             busy_o, done_o, err_o}, 0);
    check("async_rst_tail", tail_word_o, 0);
    flush();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    push_load(32, 1, 32'hA5A5_0F0F, 32'h0, 32'h0);
    start_load(32);
    wait_done(200);
    check("post_rst_done_cycle", done_cyc - start_cyc, 50);
    check("post_rst_en", en_cnt, 32);
    check("post_rst_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
